// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants and types for imm_gen_pipe.
package imm_gen_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_Z    = 3'd6
   } imm_type_e;

   // Width-independent part of the buffered payload; XLEN-wide fields are added by the top.
   typedef struct packed {
      logic [31:0] inst;
      imm_type_e   imm_type;
      logic        target_vld;
   } imm_meta_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decoder.
// IMM_GEN_ZICSR_EN enables the CSR zimm (IMM_Z) format for SYSTEM opcodes.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type
);

   logic [31:0] imm32;

   always_comb begin
      imm32    = '0;
      imm_type = IMM_NONE;
      case (inst[6:0])
         OP_IMM, LOAD, JALR: begin
            imm32    = {{20{inst[31]}}, inst[31:20]};
            imm_type = IMM_I;
         end
         STORE: begin
            imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            imm_type = IMM_S;
         end
         BRANCH: begin
            imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            imm_type = IMM_B;
         end
         LUI, AUIPC: begin
            imm32    = {inst[31:12], 12'b0};
            imm_type = IMM_U;
         end
         JAL: begin
            imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            imm_type = IMM_J;
         end
`ifdef IMM_GEN_ZICSR_EN
         SYSTEM: begin
            if (inst[14]) begin
               imm32    = {27'b0, inst[19:15]};
               imm_type = IMM_Z;
            end
         end
`endif
         default: begin
            imm32    = '0;
            imm_type = IMM_NONE;
         end
      endcase
   end

   // Bit 31 of imm32 is 0 for zimm, so one signed widening covers every format.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with 2-entry output buffer (output + skid).
// Optional CSR zimm decode via IMM_GEN_ZICSR_EN (handled in imm_decode).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_inst,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_imm_type,
   output logic [XLEN-1:0] o_target,
   output logic            o_target_vld,
   output logic [XLEN-1:0] o_pc,
   output logic [31:0]     o_inst
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] pc;
      imm_meta_t       meta;
   } payload_t;

   logic [XLEN-1:0] dec_imm;
   imm_type_e       dec_type;
   logic            dec_tvld;
   payload_t        in_pl;

   payload_t out_q, out_d, skid_q, skid_d;
   logic     out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, ready_q;
   logic     accept, drain;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst     (i_inst),
      .imm      (dec_imm),
      .imm_type (dec_type)
   );

   always_comb begin
      dec_tvld              = (dec_type == IMM_B) || (dec_type == IMM_J) || (i_inst[6:0] == AUIPC);
      in_pl.imm             = dec_imm;
      in_pl.target          = dec_tvld ? (i_pc + dec_imm) : '0;
      in_pl.pc              = i_pc;
      in_pl.meta.inst       = i_inst;
      in_pl.meta.imm_type   = dec_type;
      in_pl.meta.target_vld = dec_tvld;
   end

   assign accept = i_valid && ready_q;
   assign drain  = out_vld_q && i_ready;

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!out_vld_q || drain) begin
         if (skid_vld_q) begin
            // Skid drains into the output register and may refill in the same cycle.
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = accept;
            if (accept) skid_d = in_pl;
         end else begin
            out_vld_d = accept;
            if (accept) out_d = in_pl;
         end
      end else if (accept) begin
         skid_d     = in_pl;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         ready_q    <= !skid_vld_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_valid      = out_vld_q;
   assign o_imm        = out_q.imm;
   assign o_imm_type   = out_q.meta.imm_type;
   assign o_target     = out_q.target;
   assign o_target_vld = out_q.meta.target_vld;
   assign o_pc         = out_q.pc;
   assign o_inst       = out_q.meta.inst;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. Accepts one 32-bit instruction word plus its PC per cycle over a valid/ready handshake and produces an XLEN-wide sign-extended immediate, an immediate-type code and, for PC-relative formats, a precomputed target address. A 2-entry output buffer (output register plus skid register) gives full throughput with a registered `o_ready`.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: synchronous, active-low reset; one clock.
- `i_valid`, input, 1: upstream word valid.
- `o_ready`, output, 1: block can accept a word; registered.
- `i_inst`, input, 32: instruction word.
- `i_pc`, input, XLEN: PC of the instruction.
- `o_valid`, output, 1: result valid.
- `i_ready`, input, 1: downstream accepts the result.
- `o_imm`, output, XLEN: sign-extended immediate.
- `o_imm_type`, output, 3: `imm_type_e` code.
- `o_target`, output, XLEN: `pc + imm`.
- `o_target_vld`, output, 1: `o_target` is meaningful.
- `o_pc`, output, XLEN: PC passed through with the result.
- `o_inst`, output, 32: instruction passed through with the result.

## Operation
- Decode by `i_inst[6:0]`:
  - OP-IMM, LOAD, JALR: I-format.
  - STORE: S-format.
  - BRANCH: B-format.
  - LUI, AUIPC: U-format.
  - JAL: J-format.
  - Anything else, including `i_inst[1:0]` != 2'b11: `IMM_NONE`, `o_imm` = 0.
- Sign extension: from `inst[31]` to XLEN. U-format is `{inst[31:12], 12'b0}` sign-extended to XLEN; this matters for RV64.
- B and J formats carry `imm[0]` = 0.
- `o_target` = `i_pc + imm`, modulo 2^XLEN (wraps, no flag).
- `o_target_vld` = 1 for B, J and AUIPC; 0 otherwise, with `o_target` = 0 in that case. JALR is 0 because it depends on rs1.
- Accept a word when `i_valid && o_ready`.
- Result transfers downstream when `o_valid && i_ready`.
- Buffer behaviour:
  - Output register empty, or draining this cycle with skid empty: the accepted word loads the output register.
  - Output register full and stalled: the accepted word loads the skid register.
  - Output drains while skid is full: skid moves to the output register. The skid then refills in the same cycle if a word is also accepted.
- Order is always preserved. No word is dropped or duplicated.
- `o_ready` next-state = NOT (skid valid next); the value is held 0 while in reset.

## Timing
- Latency: 1 cycle from acceptance to `o_valid`, when no stall is present.
- Throughput: 1 word per cycle while `i_ready` is held high.
- Reset values: `o_valid`=0, `o_ready`=0, and `o_imm`, `o_imm_type`, `o_target`, `o_target_vld`, `o_pc`, `o_inst` all 0. Skid valid is also 0.
- `o_ready` rises in the first cycle after `i_rst_n` is released.
- Reset mid-operation discards both buffered words. No handshake completes in the reset cycle.
- While `o_valid && !i_ready`, all outputs hold stable.
- `i_valid` may fall without a transfer. Upstream data is sampled only on acceptance.

## Configuration
- `IMM_GEN_ZICSR_EN` defined:
  - SYSTEM opcode (1110011) with `inst[14]`=1 yields `IMM_Z`.
  - `o_imm` = zero-extended `inst[19:15]`.
  - `o_target_vld`=0.
- Undefined: SYSTEM yields `IMM_NONE` with `o_imm`=0. The `IMM_Z` encoding stays reserved in the package.

## Structure
- Package `imm_gen_pkg` holds:
  - opcode localparams: OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM;
  - `typedef enum logic [2:0] imm_type_e` {`IMM_NONE`, `IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_Z`};
  - a packed struct for the buffered payload.
- Sub-module `imm_decode`, purely combinational: `inst` → `imm` and `imm_type`, parametrised by XLEN.
- The top level holds the adder, the output and skid registers, and the handshake logic.

## Test plan
- XLEN=32, `i_inst`=0xFFF00093 (addi x1,x0,-1) → `o_imm`=0xFFFFFFFF, `IMM_I`, `o_target_vld`=0, one cycle after acceptance.
- `i_inst`=0xFE000EE3 (beq -4), `i_pc`=0x100 → `o_imm`=0xFFFFFFFC, `IMM_B`, `o_target`=0xFC, `o_target_vld`=1.
- XLEN=64, `i_inst`=0x800002B7 (lui x5,0x80000) → `o_imm`=0xFFFFFFFF80000000, `IMM_U`.
- Backpressure: `i_ready`=0 for 3 cycles while offering 4 back-to-back words → exactly 2 accepted and `o_ready`=0. After release, the words emerge in order on consecutive cycles and the rest are then accepted.
- `i_inst`=0x34015073 (csrrwi x0,0x340,2) → with `IMM_GEN_ZICSR_EN`: `o_imm`=2, `IMM_Z`. Without it: `o_imm`=0, `IMM_NONE`.
- Both buffer entries full, then `i_rst_n`=0 for one cycle → `o_valid`=0 and `o_ready`=0 in the next cycle, `o_ready`=1 one cycle after release, and no stale word is emitted.
